// File: rtl/seq_div_datapath.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_datapath
// Brief    : Operand registers and multi-cycle restoring divider that answer
//            the operation-control FSM (load strobes, validate, start) with
//            a divide-by-zero flag and a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div_datapath #(
   parameter int W      = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] data_in,
   input  logic         load_x,
   input  logic         load_y,
   input  logic         val,
   input  logic         op_en,
   output logic         error,
   output logic         error_latched,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);

   localparam int c_cnt_w = $clog2(W + 1);
   localparam logic [c_cnt_w-1:0] c_iters = c_cnt_w'(W);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       x_q, x_d;
   logic [W-1:0]       y_q, y_d;
   logic [W-1:0]       a_q, a_d;          // partial remainder
   logic [W-1:0]       wq_q, wq_d;        // working quotient / shifted dividend
   logic [W-1:0]       m_q, m_d;          // divisor magnitude snapshot
   logic [c_cnt_w-1:0] cnt_q, cnt_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic [W-1:0]       quot_q, quot_d;
   logic [W-1:0]       rem_q, rem_d;
   logic               errl_q, errl_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               w_x_neg;
   logic               w_y_neg;
   logic [W-1:0]       w_x_mag;
   logic [W-1:0]       w_y_mag;
   logic [W:0]         w_shift;
   logic               w_ge;
   logic [W-1:0]       w_rest;

   // Operand signs/magnitudes; the most-negative value maps to 2^(W-1) as an
   // unsigned magnitude, which is exactly what makes MIN / -1 wrap cleanly.
   assign w_x_neg = SIGNED && x_q[W-1];
   assign w_y_neg = SIGNED && y_q[W-1];
   assign w_x_mag = w_x_neg ? (~x_q + 1'b1) : x_q;
   assign w_y_mag = w_y_neg ? (~y_q + 1'b1) : y_q;

   // One restoring step: shifted partial remainder is W+1 bits wide, but when
   // it is >= M the difference is < M and fits back into W bits.
   assign w_shift = {a_q, wq_q[W-1]};
   assign w_ge    = (w_shift >= {1'b0, m_q});
   assign w_rest  = w_shift[W-1:0] - m_q;

   assign error         = (y_q == '0);
   assign error_latched = errl_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign quotient      = quot_q;
   assign remainder     = rem_q;

   // Next-state, operand load and divider iteration logic.
   always_comb begin
      state_d = state_q;
      x_d     = load_x ? data_in : x_q;
      y_d     = load_y ? data_in : y_q;
      a_d     = a_q;
      wq_d    = wq_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      errl_d  = val ? error : errl_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // Start decision uses the pre-edge Y, so a coincident load_y
            // only affects the next operation.
            if (op_en && !error) begin
               a_d     = '0;
               wq_d    = w_x_mag;
               m_d     = w_y_mag;
               negq_d  = w_x_neg ^ w_y_neg;
               negr_d  = w_x_neg;
               cnt_d   = c_iters;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            a_d   = w_ge ? w_rest : w_shift[W-1:0];
            wq_d  = {wq_q[W-2:0], w_ge};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == c_last) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            quot_d  = negq_q ? (~wq_q + 1'b1) : wq_q;
            rem_d   = negr_q ? (~a_q + 1'b1) : a_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         a_q     <= '0;
         wq_q    <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         errl_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         a_q     <= a_d;
         wq_q    <= wq_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         errl_q  <= errl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_div_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_div_datapath
// Brief    : Directed self-checking bench; an unsigned and a signed instance
//            share every input and are checked against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div_datapath;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_in = 8'd0;
   logic       load_x = 1'b0;
   logic       load_y = 1'b0;
   logic       val = 1'b0;
   logic       op_en = 1'b0;

   logic       err_u, errl_u, busy_u, done_u;
   logic [7:0] quot_u, rem_u;
   logic       err_s, errl_s, busy_s, done_s;
   logic [7:0] quot_s, rem_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_div_datapath #(.W(8), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .data_in(data_in), .load_x(load_x), .load_y(load_y),
      .val(val), .op_en(op_en), .error(err_u), .error_latched(errl_u),
      .busy(busy_u), .done(done_u), .quotient(quot_u), .remainder(rem_u)
   );

   seq_div_datapath #(.W(8), .SIGNED(1'b1)) u_dut_s (
      .clk(clk), .rst(rst), .data_in(data_in), .load_x(load_x), .load_y(load_y),
      .val(val), .op_en(op_en), .error(err_s), .error_latched(errl_s),
      .busy(busy_s), .done(done_s), .quotient(quot_s), .remainder(rem_s)
   );

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ops(input logic [7:0] x, input logic [7:0] y);
      data_in = x; load_x = 1'b1; tick(); load_x = 1'b0;
      data_in = y; load_y = 1'b1; tick(); load_y = 1'b0;
   endtask

   // Called right after the op_en edge (edge 1); returns the edge number at
   // which done was first seen and the number of cycles busy was high.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 1;
      bcnt = busy_u ? 1 : 0;
      while (!done_u && lat < 40) begin
         tick();
         lat++;
         if (busy_u) bcnt++;
      end
   endtask

   task automatic pulse_op();
      op_en = 1'b1; tick(); op_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      n_checks++; if ({quot_u, rem_u, quot_s, rem_s} !== 32'h0) begin n_fail++;
         $display("FAIL reset_results got %h want 00000000", {quot_u, rem_u, quot_s, rem_s}); end
      n_checks++; if ({busy_u, done_u, errl_u, busy_s, done_s, errl_s} !== 6'b0) begin n_fail++;
         $display("FAIL reset_flags got %b want 000000", {busy_u, done_u, errl_u, busy_s, done_s, errl_s}); end
      n_checks++; if ({err_u, err_s} !== 2'b11) begin n_fail++;
         $display("FAIL reset_error got %b want 11", {err_u, err_s}); end
   endtask

   task automatic test_unsigned();
      int lat, bcnt;
      load_ops(8'd100, 8'd7);
      pulse_op();
      wait_done(lat, bcnt);
      n_checks++; if (lat !== 10) begin n_fail++;
         $display("FAIL u_latency got %0d want 10", lat); end
      n_checks++; if (bcnt !== 9) begin n_fail++;
         $display("FAIL u_busy_cycles got %0d want 9", bcnt); end
      n_checks++; if ({quot_u, rem_u} !== {8'd14, 8'd2}) begin n_fail++;
         $display("FAIL u_100_7 got q=%0d r=%0d want q=14 r=2", quot_u, rem_u); end
      tick();
      n_checks++; if (done_u !== 1'b0) begin n_fail++;
         $display("FAIL u_done_width got %b want 0", done_u); end
      load_ops(8'd255, 8'd255);
      pulse_op();
      wait_done(lat, bcnt);
      n_checks++; if ({quot_u, rem_u} !== {8'd1, 8'd0}) begin n_fail++;
         $display("FAIL u_255_255 got q=%0d r=%0d want q=1 r=0", quot_u, rem_u); end
   endtask

   task automatic test_div_zero();
      int dcnt;
      data_in = 8'd0; load_y = 1'b1; tick(); load_y = 1'b0;
      n_checks++; if (err_u !== 1'b1) begin n_fail++;
         $display("FAIL dz_error got %b want 1", err_u); end
      n_checks++; if (errl_u !== 1'b0) begin n_fail++;
         $display("FAIL dz_latched_hold got %b want 0", errl_u); end
      val = 1'b1; tick(); val = 1'b0;
      n_checks++; if (errl_u !== 1'b1) begin n_fail++;
         $display("FAIL dz_latched got %b want 1", errl_u); end
      pulse_op();
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (busy_u || done_u) dcnt++;
         tick();
      end
      n_checks++; if (dcnt !== 0) begin n_fail++;
         $display("FAIL dz_no_start got %0d busy/done cycles want 0", dcnt); end
      n_checks++; if ({quot_u, rem_u} !== {8'd1, 8'd0}) begin n_fail++;
         $display("FAIL dz_results_held got q=%0d r=%0d want q=1 r=0", quot_u, rem_u); end
      data_in = 8'd3; load_y = 1'b1; tick(); load_y = 1'b0;
      n_checks++; if (err_u !== 1'b0) begin n_fail++;
         $display("FAIL dz_error_clear got %b want 0", err_u); end
      n_checks++; if (errl_u !== 1'b1) begin n_fail++;
         $display("FAIL dz_latched_no_val got %b want 1", errl_u); end
   endtask

   task automatic test_signed();
      int lat, bcnt;
      load_ops(8'hF9, 8'h02);
      pulse_op(); wait_done(lat, bcnt);
      n_checks++; if ({quot_s, rem_s} !== {8'hFD, 8'hFF}) begin n_fail++;
         $display("FAIL s_m7_2 got q=%h r=%h want q=fd r=ff", quot_s, rem_s); end
      n_checks++; if ({quot_u, rem_u} !== {8'd124, 8'd1}) begin n_fail++;
         $display("FAIL u_249_2 got q=%0d r=%0d want q=124 r=1", quot_u, rem_u); end
      load_ops(8'h07, 8'hFE);
      pulse_op(); wait_done(lat, bcnt);
      n_checks++; if ({quot_s, rem_s} !== {8'hFD, 8'h01}) begin n_fail++;
         $display("FAIL s_7_m2 got q=%h r=%h want q=fd r=01", quot_s, rem_s); end
      load_ops(8'h80, 8'hFF);
      pulse_op(); wait_done(lat, bcnt);
      n_checks++; if (done_s !== 1'b1 || err_s !== 1'b0) begin n_fail++;
         $display("FAIL s_min_done got done=%b err=%b want done=1 err=0", done_s, err_s); end
      n_checks++; if ({quot_s, rem_s} !== {8'h80, 8'h00}) begin n_fail++;
         $display("FAIL s_min_m1 got q=%h r=%h want q=80 r=00", quot_s, rem_s); end
      n_checks++; if ({quot_u, rem_u} !== {8'd0, 8'd128}) begin n_fail++;
         $display("FAIL u_128_255 got q=%0d r=%0d want q=0 r=128", quot_u, rem_u); end
   endtask

   task automatic test_busy_ignore();
      int lat, bcnt;
      load_ops(8'd100, 8'd7);
      pulse_op();                       // edge 1
      tick(); tick();                   // edges 2, 3
      data_in = 8'd9; load_x = 1'b1; op_en = 1'b1;
      tick();                           // edge 4
      load_x = 1'b0; op_en = 1'b0;
      lat = 4; bcnt = 0;
      while (!done_u && lat < 40) begin tick(); lat++; end
      n_checks++; if (lat !== 10) begin n_fail++;
         $display("FAIL bi_latency got %0d want 10", lat); end
      n_checks++; if ({quot_u, rem_u} !== {8'd14, 8'd2}) begin n_fail++;
         $display("FAIL bi_result got q=%0d r=%0d want q=14 r=2", quot_u, rem_u); end
      tick();
      n_checks++; if (busy_u !== 1'b0 || done_u !== 1'b0) begin n_fail++;
         $display("FAIL bi_no_restart got busy=%b done=%b want 0 0", busy_u, done_u); end
      pulse_op(); wait_done(lat, bcnt);
      n_checks++; if ({quot_u, rem_u} !== {8'd1, 8'd2}) begin n_fail++;
         $display("FAIL bi_9_7 got q=%0d r=%0d want q=1 r=2", quot_u, rem_u); end
   endtask

   task automatic test_coincident_load_y();
      int lat, bcnt;
      load_ops(8'd100, 8'd7);
      data_in = 8'd0; load_y = 1'b1; op_en = 1'b1;
      tick();
      load_y = 1'b0; op_en = 1'b0;
      n_checks++; if (busy_u !== 1'b1 || err_u !== 1'b1) begin n_fail++;
         $display("FAIL cy_start got busy=%b err=%b want 1 1", busy_u, err_u); end
      wait_done(lat, bcnt);
      n_checks++; if ({quot_u, rem_u} !== {8'd14, 8'd2}) begin n_fail++;
         $display("FAIL cy_result got q=%0d r=%0d want q=14 r=2", quot_u, rem_u); end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, dcnt;
      load_ops(8'd50, 8'd5);
      pulse_op();                       // edge 1
      tick(); tick(); tick();           // edges 2..4
      rst = 1'b1; tick(); rst = 1'b0;   // edge 5
      n_checks++; if ({busy_u, done_u, errl_u, quot_u, rem_u} !== 19'h0) begin n_fail++;
         $display("FAIL rm_clear got busy=%b done=%b el=%b q=%h r=%h want all 0",
                  busy_u, done_u, errl_u, quot_u, rem_u); end
      n_checks++; if (err_u !== 1'b1) begin n_fail++;
         $display("FAIL rm_error got %b want 1", err_u); end
      dcnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done_u || busy_u) dcnt++;
      end
      n_checks++; if (dcnt !== 0) begin n_fail++;
         $display("FAIL rm_no_done got %0d busy/done cycles want 0", dcnt); end
      load_ops(8'd50, 8'd5);
      pulse_op(); wait_done(lat, bcnt);
      n_checks++; if (lat !== 10 || {quot_u, rem_u} !== {8'd10, 8'd0}) begin n_fail++;
         $display("FAIL rm_recover got lat=%0d q=%0d r=%0d want lat=10 q=10 r=0", lat, quot_u, rem_u); end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_div_zero();
      test_signed();
      test_busy_ignore();
      test_coincident_load_y();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
